// File: rtl/stream_intf_pkg.sv
// Shared definitions for Mage stream interfaces (output-collector subset).
// Holds the per-stream sizing constants, the collector FSM state type,
// the crossbar source-select type and a saturating-add helper used by the
// optional drop counter.
package stream_intf_pkg;

    localparam int N_PEA_DOUT_PER_OUT_STREAM     = 2;
    localparam int N_DMA_CH_PER_OUT_STREAM       = 2;
    localparam int LOG_N_PEA_DOUT_PER_OUT_STREAM = 1;
    localparam int OUT_FIFO_DEPTH                = 4;
    localparam int OUT_OVF_CNT_W                 = 16;

    typedef logic [LOG_N_PEA_DOUT_PER_OUT_STREAM-1:0] out_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } out_coll_state_e;

    function automatic logic [OUT_OVF_CNT_W-1:0] sat_add_ovf(
        input logic [OUT_OVF_CNT_W-1:0] a,
        input logic [OUT_OVF_CNT_W-1:0] b
    );
        logic [OUT_OVF_CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[OUT_OVF_CNT_W] ? {OUT_OVF_CNT_W{1'b1}} : s[OUT_OVF_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mage_stream_fifo.sv
// Single-write / single-read show-ahead FIFO used to buffer one PEA output.
// rdata_o always presents the head word; pop_i consumes it. A push while
// full is accepted only when a pop happens in the same cycle. flush_i empties
// the FIFO synchronously.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   flush_i          synchronous empty
//   push_i, wdata_i  write request and data
//   pop_i            consume head word
//   rdata_o          head word (valid when !empty_o)
//   empty_o, full_o  status
//   count_o          occupancy, one bit wider than the pointers
module mage_stream_fifo
    import stream_intf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = OUT_FIFO_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == CW'(DEPTH));
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign rdata_o   = r_mem[r_rptr];
    assign count_o   = r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr] <= wdata_i;
    end

endmodule

// File: rtl/mage_out_stream_collector.sv
// Output-side stream collector: buffers the PEA outputs of one output stream
// in per-output FIFOs and routes them through a per-channel source crossbar
// to the stream's DMA channels with a valid/ready handshake. Each enabled
// channel delivers exactly the latched length, then done_o pulses.
//
// Optional feature: define MAGE_OUT_STREAM_OVF_CNT_EN to add ovf_cnt_o, a
// 16-bit saturating count of dropped PEA words (cleared at a start that
// enters RUN).
//
// Ports:
//   clk_i, rst_i       clock, async active-high reset
//   cfg_start_i        start pulse (honoured only in IDLE)
//   cfg_ch_en_i        per-channel enable
//   cfg_sel_i          per-channel PEA source select
//   cfg_len_i          words per enabled channel
//   pea_dout_i         PEA output data
//   pea_dout_valid_i   PEA output valid (no backpressure)
//   pea_stall_o        per-PEA-output almost-full warning
//   dma_data_o         DMA channel data
//   dma_valid_o        DMA channel valid
//   dma_ready_i        DMA channel ready
//   busy_o             high while in RUN
//   done_o             one-cycle pulse at transfer end
//   ovf_o              sticky: a PEA word was dropped
//   ovf_cnt_o          dropped-word count (feature build only)
//
// FSM:
//   state | meaning
//   IDLE  | waiting for cfg_start_i
//   RUN   | collecting PEA words and serving DMA channels
//   DONE  | done_o pulse, FIFOs flushed
module mage_out_stream_collector
    import stream_intf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_PEA      = N_PEA_DOUT_PER_OUT_STREAM,
    parameter int N_CH       = N_DMA_CH_PER_OUT_STREAM,
    parameter int FIFO_DEPTH = OUT_FIFO_DEPTH,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          cfg_start_i,
    input  logic [N_CH-1:0]                               cfg_ch_en_i,
    input  logic [N_CH*LOG_N_PEA_DOUT_PER_OUT_STREAM-1:0] cfg_sel_i,
    input  logic [LEN_WIDTH-1:0]                          cfg_len_i,
    input  logic [N_PEA*DATA_WIDTH-1:0]                   pea_dout_i,
    input  logic [N_PEA-1:0]                              pea_dout_valid_i,
    output logic [N_PEA-1:0]                              pea_stall_o,
    output logic [N_CH*DATA_WIDTH-1:0]                    dma_data_o,
    output logic [N_CH-1:0]                               dma_valid_o,
    input  logic [N_CH-1:0]                               dma_ready_i,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic                                          ovf_o
`ifdef MAGE_OUT_STREAM_OVF_CNT_EN
    ,
    output logic [OUT_OVF_CNT_W-1:0]                      ovf_cnt_o
`endif
);

    localparam int SEL_W = LOG_N_PEA_DOUT_PER_OUT_STREAM;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]        STALL_LVL = CW'(FIFO_DEPTH - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

    out_coll_state_e r_state;
    out_coll_state_e w_state_next;
    logic            w_load;
    logic            w_run;
    logic            w_flush;
    logic            w_all_done;

    logic [N_CH-1:0]       r_en;
    logic [N_CH-1:0]       r_taken;
    out_sel_t              r_sel [N_CH];
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt [N_CH];
    logic                  r_ovf;

    logic [N_CH-1:0]       w_at_len;
    logic [N_CH-1:0]       w_active;
    logic [N_CH-1:0]       w_valid;
    logic [N_CH-1:0]       w_hs;

    logic [N_PEA-1:0]      w_push;
    logic [N_PEA-1:0]      w_pop;
    logic [N_PEA-1:0]      w_pop_ok;
    logic [N_PEA-1:0]      w_pop_any;
    logic [N_PEA-1:0]      w_empty;
    logic [N_PEA-1:0]      w_full;
    logic [N_PEA-1:0]      w_drop;
    logic [DATA_WIDTH-1:0] w_rdata [N_PEA];
    logic [CW-1:0]         w_count [N_PEA];

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start_i) begin
                    if ((cfg_len_i != '0) && (|cfg_ch_en_i)) begin
                        w_state_next = RUN;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            RUN:     if (w_all_done) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_run   = (r_state == RUN);
    assign w_flush = (r_state == DONE);
    assign busy_o  = w_run;
    assign done_o  = (r_state == DONE);
    assign ovf_o   = r_ovf;

    assign w_all_done = &(~r_en | w_at_len);

    // ---------------- FIFOs ----------------
    for (genvar p = 0; p < N_PEA; p++) begin : g_fifo
        mage_stream_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (w_flush),
            .push_i  (w_push[p]),
            .wdata_i (pea_dout_i[p*DATA_WIDTH +: DATA_WIDTH]),
            .pop_i   (w_pop[p]),
            .rdata_o (w_rdata[p]),
            .empty_o (w_empty[p]),
            .full_o  (w_full[p]),
            .count_o (w_count[p])
        );

        assign w_push[p]      = w_run & pea_dout_valid_i[p];
        assign w_drop[p]      = w_push[p] & w_full[p] & ~w_pop[p];
        assign w_pop[p]       = w_run & w_pop_any[p] & w_pop_ok[p];
        assign pea_stall_o[p] = w_run & (w_count[p] >= STALL_LVL);
    end

    // ---------------- channel crossbar ----------------
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign w_at_len[c]    = (r_cnt[c] == r_len);
        assign w_active[c]    = r_en[c] & ~w_at_len[c];
        assign w_valid[c]     = w_run & w_active[c] & ~w_empty[r_sel[c]] & ~r_taken[c];
        assign w_hs[c]        = w_valid[c] & dma_ready_i[c];
        assign dma_valid_o[c] = w_valid[c];
        // Data is gated by valid so idle/reset outputs are a clean zero.
        assign dma_data_o[c*DATA_WIDTH +: DATA_WIDTH] = w_valid[c] ? w_rdata[r_sel[c]] : '0;
    end

    // A FIFO pops once every still-active consumer has either taken the head
    // word earlier or takes it now. At least one handshake this cycle is
    // required so a FIFO nobody reads is never drained silently.
    always_comb begin
        w_pop_ok  = '1;
        w_pop_any = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_active[c]) begin
                if (!(w_hs[c] || r_taken[c])) w_pop_ok[r_sel[c]]  = 1'b0;
                if (w_hs[c])                  w_pop_any[r_sel[c]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en    <= '0;
            r_len   <= '0;
            r_taken <= '0;
            r_ovf   <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_sel[c] <= '0;
                r_cnt[c] <= '0;
            end
        end else if (w_load) begin
            r_en    <= cfg_ch_en_i;
            r_len   <= cfg_len_i;
            r_taken <= '0;
            r_ovf   <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_sel[c] <= cfg_sel_i[c*SEL_W +: SEL_W];
                r_cnt[c] <= '0;
            end
        end else if (w_run) begin
            if (|w_drop) r_ovf <= 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                if (w_hs[c]) r_cnt[c] <= r_cnt[c] + LEN_ONE;
                if (w_pop[r_sel[c]])  r_taken[c] <= 1'b0;
                else if (w_hs[c])     r_taken[c] <= 1'b1;
            end
        end else begin
            r_taken <= '0;
        end
    end

`ifdef MAGE_OUT_STREAM_OVF_CNT_EN
    logic [OUT_OVF_CNT_W-1:0] r_ovf_cnt;
    logic [OUT_OVF_CNT_W-1:0] w_drop_cnt;

    always_comb begin
        w_drop_cnt = '0;
        for (int p = 0; p < N_PEA; p++) begin
            w_drop_cnt = w_drop_cnt + OUT_OVF_CNT_W'(w_drop[p]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       r_ovf_cnt <= '0;
        else if (w_load) r_ovf_cnt <= '0;
        else if (w_run)  r_ovf_cnt <= sat_add_ovf(r_ovf_cnt, w_drop_cnt);
    end

    assign ovf_cnt_o = r_ovf_cnt;
`endif

endmodule
